// File: rtl/remote_req_fifo.sv
// Purpose : circular-buffer queue between core remote requests and network_tx; exports occupancy for fence logic.
// Latency : 1 cycle enqueue-to-head; 0 cycles when REMOTE_REQ_FIFO_BYPASS_EN is defined and the queue is empty.
// Backpres: req_yumi_o = req_v_i & ~full (never depends on req_yumi_i); head is held until req_yumi_i.
module remote_req_fifo #(
    parameter int req_width_p    = 32,
    parameter int els_p          = 2,
    localparam int count_width_lp = $clog2(els_p + 1),
    localparam int ptr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [req_width_p-1:0]    req_i,
    input  logic                      req_v_i,
    output logic                      req_yumi_o,
    output logic [req_width_p-1:0]    req_o,
    output logic                      req_v_o,
    input  logic                      req_yumi_i,
    output logic [count_width_lp-1:0] count_o,
    output logic                      empty_o,
    output logic                      full_o
);

    localparam logic [ptr_width_lp-1:0]   last_ptr_lp  = ptr_width_lp'(els_p - 1);
    localparam logic [count_width_lp-1:0] full_cnt_lp  = count_width_lp'(els_p);

    logic [req_width_p-1:0]    r_mem [els_p];
    logic [ptr_width_lp-1:0]   r_wptr;
    logic [ptr_width_lp-1:0]   r_rptr;
    logic [count_width_lp-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_accept;
    logic w_write;
    logic w_pop;
    logic w_req_v;

    // Status flags come only from the registered count
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == full_cnt_lp);
    assign w_accept = req_v_i & ~w_full;
    // Only a real stored head can be popped; an illegal yumi on empty is ignored
    assign w_pop    = req_yumi_i & ~w_empty;

`ifdef REMOTE_REQ_FIFO_BYPASS_EN
    // When empty the incoming request is presented directly; if taken this cycle it is not stored
    assign w_req_v = ~w_empty | req_v_i;
    assign req_o   = w_empty ? req_i : r_mem[r_rptr];
    assign w_write = w_accept & ~(w_empty & req_yumi_i);
`else
    assign w_req_v = ~w_empty;
    assign req_o   = r_mem[r_rptr];
    assign w_write = w_accept;
`endif

    assign req_yumi_o = w_accept;
    assign req_v_o    = w_req_v;
    assign count_o    = r_count;
    assign empty_o    = w_empty;
    assign full_o     = w_full;

    // Storage write; contents are opaque and need no reset
    always_ff @(posedge clk_i) begin
        if (w_write) begin
            r_mem[r_wptr] <= req_i;
        end
    end

    // Pointers wrap explicitly at els_p-1; count tracks push/pop, reset wins
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_write) begin
                r_wptr <= (r_wptr == last_ptr_lp) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == last_ptr_lp) ? '0 : r_rptr + 1'b1;
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Flag a consumer that takes a head that does not exist
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(req_yumi_i && !w_req_v))
                else $error("remote_req_fifo: req_yumi_i asserted while req_v_o is low");
        end
    end

endmodule

// File: tb/tb_remote_req_fifo.sv
// Purpose : directed bench for remote_req_fifo at depths 2 and 3.
// Latency : checks 1-cycle enqueue-to-head (0 with bypass macro).
// Backpres: checks push refusal when full, including pop-while-full.
module tb_remote_req_fifo;

    int n_chk  = 0;
    int n_fail = 0;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b1;

    // depth-2 instance
    logic [31:0] d2 = '0;
    logic        v2 = 1'b0;
    logic        y2 = 1'b0;
    logic        ry2, qv2, e2, f2;
    logic [31:0] q2;
    logic [1:0]  cnt2;

    // depth-3 instance
    logic [31:0] d3 = '0;
    logic        v3 = 1'b0;
    logic        y3 = 1'b0;
    logic        ry3, qv3, e3, f3;
    logic [31:0] q3;
    logic [2:0]  cnt3;

    logic [31:0] model [$];
    logic [31:0] exp_d;
    int          deliv;
    int          exp_deliv;

    always #5 clk_i = ~clk_i;

    remote_req_fifo #(.req_width_p(32), .els_p(2)) u2 (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_i(d2), .req_v_i(v2), .req_yumi_o(ry2),
        .req_o(q2), .req_v_o(qv2), .req_yumi_i(y2),
        .count_o(cnt2), .empty_o(e2), .full_o(f2)
    );

    remote_req_fifo #(.req_width_p(32), .els_p(3)) u3 (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_i(d3), .req_v_i(v3), .req_yumi_o(ry3),
        .req_o(q3), .req_v_o(qv3), .req_yumi_i(y3),
        .count_o(cnt3), .empty_o(e3), .full_o(f3)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset held 2 cycles with a valid request present
        reset_i = 1'b1; v2 = 1'b1; d2 = 32'h11;
        step(); step();
        chk("rst_v_o", qv2, 1'b0);
        chk("rst_empty", e2, 1'b1);
        chk("rst_count", cnt2, 2'd0);
        chk("rst_full", f2, 1'b0);
        chk("rst3_empty", e3, 1'b1);

        // release, fill depth-2 without consuming
        reset_i = 1'b0;
        #1;
        chk("fill_yumi0", ry2, 1'b1);
        step();
        chk("fill_cnt1", cnt2, 2'd1);
        chk("fill_head", q2, 32'h11);
        chk("fill_v_o", qv2, 1'b1);
        d2 = 32'h22;
        step();
        chk("fill_cnt2", cnt2, 2'd2);
        chk("fill_full", f2, 1'b1);
        chk("fill_yumi_full", ry2, 1'b0);
        d2 = 32'h33;
        step();
        chk("fill_cnt3", cnt2, 2'd2);
        chk("fill_head_hold", q2, 32'h11);

        // pop while full: push refused this cycle, accepted next
        y2 = 1'b1; d2 = 32'h44;
        #1;
        chk("fullpop_yumi", ry2, 1'b0);
        chk("fullpop_head", q2, 32'h11);
        step();
        chk("fullpop_cnt", cnt2, 2'd1);
        chk("fullpop_next_head", q2, 32'h22);
        y2 = 1'b0;
        #1;
        chk("fullpop_yumi_next", ry2, 1'b1);
        step();
        chk("fullpop_cnt2", cnt2, 2'd2);
        chk("fullpop_head_stable", q2, 32'h22);

        // reset mid-operation discards both entries
        v2 = 1'b0;
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        chk("midrst_v_o", qv2, 1'b0);
        chk("midrst_cnt", cnt2, 2'd0);
        chk("midrst_empty", e2, 1'b1);
        step(); step();
        chk("midrst_idle_v_o", qv2, 1'b0);

        // streaming: consumer takes whatever is valid, scoreboard checks order
        deliv = 0;
        for (int i = 0; i < 20; i++) begin
            chk("stream_cnt_le1", (cnt2 <= 2'd1), 1'b1);
            v2 = 1'b1; d2 = 32'h1000 + i; y2 = 1'b0;
            #1;
            y2 = qv2;
            #1;
            if (ry2) model.push_back(d2);
            if (y2) begin
                chk("stream_model_nonempty", (model.size() > 0), 1'b1);
                if (model.size() > 0) begin
                    exp_d = model.pop_front();
                    chk("stream_data", q2, exp_d);
                end
                deliv++;
            end
            step();
        end
        v2 = 1'b0; y2 = 1'b0;
`ifdef REMOTE_REQ_FIFO_BYPASS_EN
        exp_deliv = 20;
`else
        exp_deliv = 19;
`endif
        chk("stream_delivered", deliv, exp_deliv);

        // depth-3 order and pointer wrap
        v3 = 1'b1; d3 = 32'hA;
        step();
        chk("ord_cnt1", cnt3, 3'd1);
        chk("ord_head_a", q3, 32'hA);
        d3 = 32'hB;
        step();
        d3 = 32'hC;
        step();
        chk("ord_cnt3", cnt3, 3'd3);
        chk("ord_full", f3, 1'b1);
        chk("ord_wptr_wrap", u3.r_wptr, 2'd0);
        v3 = 1'b0; y3 = 1'b1;
        #1;
        chk("ord_pop_a", q3, 32'hA);
        step();
        y3 = 1'b0; v3 = 1'b1; d3 = 32'hD;
        step();
        chk("ord_cnt_after_d", cnt3, 3'd3);
        v3 = 1'b0; y3 = 1'b1;
        #1;
        chk("ord_pop_b", q3, 32'hB);
        step();
        chk("ord_pop_c", q3, 32'hC);
        step();
        chk("ord_pop_d", q3, 32'hD);
        step();
        y3 = 1'b0;
        chk("ord_empty", e3, 1'b1);
        chk("ord_v_o", qv3, 1'b0);

`ifdef REMOTE_REQ_FIFO_BYPASS_EN
        // zero-latency pass-through when empty and consumed at once
        v3 = 1'b1; d3 = 32'hDEAD_BEEF; y3 = 1'b1;
        #1;
        chk("byp_v_o", qv3, 1'b1);
        chk("byp_data", q3, 32'hDEAD_BEEF);
        step();
        v3 = 1'b0; y3 = 1'b0;
        chk("byp_cnt", cnt3, 3'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/remote_req_fifo.md
# remote_req_fifo

Decoupling queue between the vanilla core's remote request output and the tile's network TX unit. It buffers up to `els_p` remote requests (loads, stores, amos, ifetch misses) so the core keeps issuing while TX stalls on `out_ready` or credits. It sits directly upstream of `network_tx`: the core drives the enqueue side, and `network_tx` consumes the dequeue side with its `remote_req_v_i`/`remote_req_yumi_o` handshake. It also exports occupancy so the core's fence logic sees queued requests as outstanding alongside network credits.

## Interface
- `req_width_p`, "inv": packed width of `remote_req_s`.
- `els_p`, 2: queue depth. Must be ≥2; need not be a power of 2.
- `count_width_lp` (localparam): `$clog2(els_p+1)`.

Ports:
- `clk_i`  in  1  clock.
- `reset_i`  in  1  reset; synchronous, active-high.
- `req_i`  in  `req_width_p`  request from core.
- `req_v_i`  in  1  core request valid.
- `req_yumi_o`  out  1  request accepted this cycle.
- `req_o`  out  `req_width_p`  head request to `network_tx`.
- `req_v_o`  out  1  head valid.
- `req_yumi_i`  in  1  `network_tx` consumes head this cycle.
- `count_o`  out  `count_width_lp`  entries held.
- `empty_o`  out  1  `count_o == 0`.
- `full_o`  out  1  `count_o == els_p`.

## Operation
- Storage is a circular buffer with a write pointer `wptr`, a read pointer `rptr` (both 0..`els_p`-1) and a counter `count`.
- Pointers increment by 1 and wrap from `els_p`-1 to 0 explicitly, not by overflow.
- Enqueue: `req_yumi_o = req_v_i & ~full_o`.
  - `req_yumi_o` never depends on `req_yumi_i`.
  - Pop-while-full does not admit a push in the same cycle.
- Dequeue: `req_v_o = ~empty_o`.
  - `req_o` is the entry at `rptr`.
  - The head is stable while `req_v_o & ~req_yumi_i`.
- Simultaneous push and pop (not full, not empty): `count` is unchanged and both pointers advance.
- `req_yumi_i` asserted while `req_v_o == 0` is illegal. The simulation assertion `$error` fires, and the state must not change.
- Request contents are opaque. The block performs no reordering and delivers strictly FIFO.
- Reset mid-operation discards all queued entries. The core is reset together with the FIFO (freeze), so nothing is lost that will be replayed.

## Timing
- Reset values: `wptr = rptr = count = 0`. Outputs after reset: `req_v_o = 0`, `req_yumi_o = 0` (until `req_v_i` is seen), `empty_o = 1`, `full_o = 0`, `count_o = 0`. `req_o` is don't-care.
- Reset has priority over push and pop in the same cycle.
- Latency without bypass: a request accepted in cycle N appears at `req_o` with `req_v_o = 1` in cycle N+1 at the earliest.
- Throughput: 1 request per cycle sustained when `els_p ≥ 2` and downstream yumis every cycle.
- `count_o`, `empty_o` and `full_o` are registered-state derived and have no combinational path from any input.
- `req_yumi_o` is combinational from `req_v_i` and registered `full`.

## Configuration
- `REMOTE_REQ_FIFO_BYPASS_EN` defined, when empty:
  - `req_v_o = req_v_i` and `req_o = req_i`.
  - If `req_yumi_i` is asserted in that cycle, the request passes through with zero latency and is not written. Otherwise it is enqueued normally.
  - This creates a combinational path `req_v_i` → `req_v_o`. `network_tx` must not make `req_yumi_i` depend combinationally on the upstream `req_yumi_o`.
- Undefined: no bypass. `req_v_o` is purely registered and minimum latency is 1 cycle.

## Test plan
- Reset then idle: hold `reset_i` 2 cycles with `req_v_i = 1` → `req_v_o = 0`, `empty_o = 1`, `count_o = 0`. Then release with `req_yumi_i = 0` for 3 cycles → `count_o` goes 1, 2, 2, `full_o = 1` at `els_p = 2`, and `req_yumi_o` deasserts when full.
- FIFO order and wrap: `els_p = 3`. Push A, B, C, pop A, push D, pop B, C, D → outputs A, B, C, D in order, and `wptr` wraps 2→0.
- Streaming: `req_v_i = 1` and `req_yumi_i = req_v_o` for 20 cycles → 19 requests delivered (20 with bypass), `count_o ≤ 1` throughout.
- Full with simultaneous pop: full, `req_v_i = 1`, `req_yumi_i = 1` → `req_yumi_o = 0`, `count_o` drops to `els_p`-1, and the push is accepted the next cycle.
- Reset mid-operation: 2 entries queued, assert `reset_i` for 1 cycle → next cycle `req_v_o = 0`, `count_o = 0`, and stale entries never emerge.
- Bypass (with macro): empty, `req_v_i = 1`, `req_i = 32'hDEAD_BEEF`, `req_yumi_i = 1` → same cycle `req_o = 32'hDEAD_BEEF`, and `count_o` stays 0.
